wb_trace_uart: RTL

- Debug/trace stage directly downstream of the pipeline write-back mux. It consumes each write-back result (outMuxWb qualified by RegWrite) and buffers it in a small FIFO.
- It then serialises each buffered word off-chip over a UART 8N1 line, least-significant byte first.
- Lets the team observe every register-file write on real hardware without a logic analyser.

---
 rtl/wb_trace_uart_if.sv | 24 ++
 rtl/wb_trace_uart.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/wb_trace_uart_if.sv
// Bundles the write-back capture inputs and the trace/UART status outputs
// of the write-back trace stage into one interface.
interface wb_trace_uart_if #(
  parameter int PTR_W = 3
);
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic             tx;
  logic             busy;
  logic [PTR_W:0]   fifo_count;
  logic             overflow;

  // Producer side: the pipeline write-back stage (or a bench standing in for it)
  modport master (
    output wb_valid, wb_data,
    input  tx, busy, fifo_count, overflow
  );

  // Consumer side: the trace UART itself
  modport slave (
    input  wb_valid, wb_data,
    output tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/wb_trace_uart.sv
// Write-back trace stage: captures every register-file write into a small
// FIFO and streams each word out over a UART 8N1 line, LSB byte first.
module wb_trace_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int PTR_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  wb_trace_uart_if.slave   bus
);

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH      = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      shreg;
  logic             tx;
  logic             busy;

  logic push;
  logic pop;
  logic bit_done;

  // Fullness and emptiness are judged on the pre-edge count only, so a push
  // into a full FIFO is dropped even when the FSM pops in the same cycle.
  assign push     = bus.wb_valid && (count != DEPTH);
  assign pop      = (state == IDLE) && (count != '0);
  assign bit_done = (timer == '0);

  assign bus.tx         = tx;
  assign bus.busy       = busy;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;

  // FIFO storage: data only, never reset; stale words are unreachable after rst
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wb_data;
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (bus.wb_valid && (count == DEPTH)) overflow <= 1'b1;
    end
  end

  // Word shift register: loaded on pop, advanced one byte per stop bit
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= mem[rd_ptr];
    end else if ((state == STOP) && bit_done && (byte_idx != 2'd3)) begin
      shreg <= shreg >> 8;
    end
  end

  // UART framing FSM; tx and busy are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            byte_idx <= '0;
            timer    <= TMR_RELOAD;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            timer   <= TMR_RELOAD;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= TMR_RELOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[3'(bit_idx + 3'd1)];
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          if (bit_done) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              timer    <= TMR_RELOAD;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
